// File: rtl/traffic_sink.sv
// Network ejection sink: stages one flit at a time, checks per-VC framing,
// counts flits/packets/errors and returns credits through a programmable delay line.
module traffic_sink #(
    parameter int unsigned VC_W   = 2,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned PAY_W  = 16,
    parameter int unsigned MAX_CD = 8,
    parameter int unsigned FLIT_W = 3 + VC_W + ID_W + LEN_W + PAY_W,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned DATA_W = ID_W + VC_W + 1 + 4 + 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] data,
    input  logic [FLIT_W-1:0] in_flit,
    output logic [VC_W:0]     cr_out,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic              done
);

    localparam int unsigned NVC     = 1 << VC_W;
    localparam int unsigned NV_W    = VC_W + 1;
    localparam int unsigned CD_W    = 4;
    localparam int unsigned EXP_W   = 16;
    localparam int unsigned VC_LSB  = 3;
    localparam int unsigned DST_LSB = VC_LSB + VC_W;
    localparam int unsigned LEN_LSB = DST_LSB + ID_W;
    localparam int unsigned PAY_LSB = LEN_LSB + LEN_W;

    localparam logic [OP_W-1:0] OP_INIT = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LOAD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_PH1  = OP_W'(4);
    localparam logic [CD_W-1:0] MAX_CD_V = CD_W'(MAX_CD);

    typedef enum logic {S_IDLE, S_BODY} vc_state_e;

    logic [ID_W-1:0]   my_id_q, my_id_d;
    logic [NV_W-1:0]   nvc_q, nvc_d;
    logic [CD_W-1:0]   cd_q, cd_d, cd_raw;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [FLIT_W-1:0] stage_q, stage_d;
    vc_state_e         state_q [NVC];
    vc_state_e         state_d [NVC];
    logic [LEN_W-1:0]  rem_q [NVC];
    logic [LEN_W-1:0]  rem_d [NVC];
    logic [VC_W:0]     line_q [MAX_CD];
    logic [VC_W:0]     line_d [MAX_CD];
    logic [VC_W:0]     cr_q, cr_d;
    logic [CNT_W-1:0]  flit_q, flit_d, pkt_q, pkt_d, err_q, err_d;
    logic              flag_q, flag_d, done_q, done_d;

    logic              s_valid, s_head, s_tail, vc_ok;
    logic [VC_W-1:0]   s_vc;
    logic [ID_W-1:0]   s_dst;
    logic [LEN_W-1:0]  s_len;
    logic [NV_W-1:0]   nvc_eff;
    logic [VC_W:0]     cr_new;
    logic              err_hit, pkt_hit, all_idle, line_empty;
    logic              unused_payload;

    assign s_valid = stage_q[0];
    assign s_head  = stage_q[1];
    assign s_tail  = stage_q[2];
    assign s_vc    = stage_q[VC_LSB +: VC_W];
    assign s_dst   = stage_q[DST_LSB +: ID_W];
    assign s_len   = stage_q[LEN_LSB +: LEN_W];
    assign unused_payload = ^stage_q[FLIT_W-1:PAY_LSB];

    // A stored num_vcs of zero still admits VC 0.
    assign nvc_eff = (nvc_q == '0) ? NV_W'(1) : nvc_q;
    assign vc_ok   = {1'b0, s_vc} < nvc_eff;
    assign cr_new  = s_valid ? {s_vc, 1'b1} : '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Next-state: op decode, framing checks, credit delay line and done.
    always_comb begin
        my_id_d    = my_id_q;
        nvc_d      = nvc_q;
        cd_d       = cd_q;
        exp_d      = exp_q;
        stage_d    = stage_q;
        state_d    = state_q;
        rem_d      = rem_q;
        line_d     = line_q;
        cr_d       = cr_q;
        flit_d     = flit_q;
        pkt_d      = pkt_q;
        err_d      = err_q;
        flag_d     = flag_q;
        err_hit    = 1'b0;
        pkt_hit    = 1'b0;
        all_idle   = 1'b1;
        line_empty = 1'b1;
        cd_raw     = data[ID_W+NV_W +: CD_W];

        case (op)
            OP_INIT: begin
                my_id_d = data[0 +: ID_W];
                nvc_d   = data[ID_W +: NV_W];
                cd_d    = (cd_raw > MAX_CD_V) ? MAX_CD_V : cd_raw;
                exp_d   = data[ID_W+NV_W+CD_W +: EXP_W];
                stage_d = '0;
                cr_d    = '0;
                flit_d  = '0;
                pkt_d   = '0;
                err_d   = '0;
                flag_d  = 1'b0;
                for (int i = 0; i < int'(NVC); i++) begin
                    state_d[i] = S_IDLE;
                    rem_d[i]   = '0;
                end
                for (int i = 0; i < int'(MAX_CD); i++) line_d[i] = '0;
            end
            OP_LOAD: stage_d = in_flit;
            OP_PH1: begin
                stage_d[0] = 1'b0;
                for (int i = 0; i < int'(MAX_CD) - 1; i++) line_d[i] = line_q[i+1];
                line_d[MAX_CD-1] = '0;
                // Credit lands in the slot that reaches the output cd edges from now.
                for (int i = 0; i < int'(MAX_CD); i++)
                    if (s_valid && cd_q == CD_W'(i + 1)) line_d[i] = cr_new;
                cr_d = (cd_q == '0) ? cr_new : line_q[0];

                if (s_valid) begin
                    flit_d = sat_inc(flit_q);
                    if (!vc_ok) begin
                        err_hit = 1'b1;
                    end else begin
                        if (s_dst != my_id_q) err_hit = 1'b1;
                        if (state_q[s_vc] == S_BODY && !s_head) begin
                            if (s_tail) begin
                                if (rem_q[s_vc] == LEN_W'(1)) pkt_hit = 1'b1;
                                else                          err_hit = 1'b1;
                                state_d[s_vc] = S_IDLE;
                            end else if (rem_q[s_vc] == LEN_W'(1)) begin
                                err_hit       = 1'b1;
                                state_d[s_vc] = S_IDLE;
                            end else begin
                                rem_d[s_vc] = rem_q[s_vc] - LEN_W'(1);
                            end
                        end else begin
                            // IDLE, or a head arriving mid-packet restarts framing.
                            if (state_q[s_vc] == S_BODY) err_hit = 1'b1;
                            state_d[s_vc] = S_IDLE;
                            if (!s_head || s_len == '0) begin
                                err_hit = 1'b1;
                            end else if (s_len == LEN_W'(1)) begin
                                if (s_tail) pkt_hit = 1'b1;
                                else        err_hit = 1'b1;
                            end else if (s_tail) begin
                                err_hit = 1'b1;
                            end else begin
                                rem_d[s_vc]   = s_len - LEN_W'(1);
                                state_d[s_vc] = S_BODY;
                            end
                        end
                    end
                    if (pkt_hit) pkt_d = sat_inc(pkt_q);
                    if (err_hit) begin
                        err_d  = sat_inc(err_q);
                        flag_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        for (int i = 0; i < int'(NVC); i++)
            if (state_d[i] != S_IDLE) all_idle = 1'b0;
        for (int i = 0; i < int'(MAX_CD); i++)
            if (line_d[i][0]) line_empty = 1'b0;
        done_d = all_idle && line_empty && !stage_d[0] && (32'(pkt_d) >= 32'(exp_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            my_id_q <= '0;
            nvc_q   <= '0;
            cd_q    <= '0;
            exp_q   <= '0;
            stage_q <= '0;
            cr_q    <= '0;
            flit_q  <= '0;
            pkt_q   <= '0;
            err_q   <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(NVC); i++) begin
                state_q[i] <= S_IDLE;
                rem_q[i]   <= '0;
            end
            for (int i = 0; i < int'(MAX_CD); i++) line_q[i] <= '0;
        end else begin
            my_id_q <= my_id_d;
            nvc_q   <= nvc_d;
            cd_q    <= cd_d;
            exp_q   <= exp_d;
            stage_q <= stage_d;
            cr_q    <= cr_d;
            flit_q  <= flit_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            for (int i = 0; i < int'(NVC); i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
            for (int i = 0; i < int'(MAX_CD); i++) line_q[i] <= line_d[i];
        end
    end

    assign cr_out   = cr_q;
    assign flit_cnt = flit_q;
    assign pkt_cnt  = pkt_q;
    assign err_cnt  = err_q;
    assign err_flag = flag_q;
    assign done     = done_q;

endmodule
